gif_frame_sequencer: RTL

- Playback controller for the 8-frame animation store (eight picture_plus frame instances).
- Owns the current-frame index and decodes it to one-hot frame enables.
- Sequences frames manually from debounced key events, or automatically at a programmable rate, with forward-loop or ping-pong order and a programmable loop length.
- Sits between the button_state debouncers and the frame instances; replaces ad-hoc frame counters clocked from derived signals. Everything runs on CLOCK_50.

---
 rtl/gif_frame_sequencer_if.sv | 32 +++
 rtl/gif_frame_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/gif_frame_sequencer_if.sv
// Control/status bundle between the key debouncers, the frame sequencer
// and the frame store. The sequencer attaches through the slave modport.
interface gif_frame_sequencer_if #(
    parameter int FRAMES = 8,
    parameter int FW     = 3
);
    logic              en;
    logic              next_short;
    logic              prev_short;
    logic              next_long;
    logic              prev_long;
    logic [1:0]        speed;
    logic              pingpong;
    logic [FW-1:0]     last_frame;
    logic [FW-1:0]     frame;
    logic [FRAMES-1:0] frame_en;
    logic              running;
    logic              adv;
    logic              dir;

    modport master (
        output en, next_short, prev_short, next_long, prev_long,
        output speed, pingpong, last_frame,
        input  frame, frame_en, running, adv, dir
    );

    modport slave (
        input  en, next_short, prev_short, next_long, prev_long,
        input  speed, pingpong, last_frame,
        output frame, frame_en, running, adv, dir
    );
endinterface

// File: rtl/gif_frame_sequencer.sv
// Playback controller for the 8-slot animation store: owns the current
// frame index, decodes it to one-hot frame enables, and steps it either
// from debounced key events (MANUAL) or from a prescaled timer (PLAY) in
// loop or ping-pong order.
module gif_frame_sequencer #(
    parameter int FRAMES      = 8,
    parameter int FW          = 3,
    parameter int DIV_W       = 24,
    parameter int BASE_PERIOD = 8388608
) (
    input logic                  CLOCK_50,
    input logic                  rst,
    gif_frame_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MANUAL, PLAY} state_t;

    localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_PERIOD);

    state_t           state, nxt_state;
    logic [FW-1:0]    nxt_frame;
    logic             nxt_dir;
    logic             nxt_adv;
    logic [DIV_W-1:0] presc, nxt_presc;
    logic [DIV_W-1:0] period_m1;
    logic [FW-1:0]    up_frame, dn_frame;
    logic             clamp;
    logic             go_up;

    // Frame-step helpers: rate-scaled period, neighbours, clamp and bounce direction.
    always_comb begin
        period_m1 = (BASE >> bus.speed) - DIV_W'(1);
        up_frame  = bus.frame + FW'(1);
        dn_frame  = bus.frame - FW'(1);
        clamp     = bus.last_frame < bus.frame;
        // Bounce climbs while below the top going up, or when sitting on 0
        // going down (turnaround without repeating the end frame).
        go_up     = (!bus.dir && (bus.frame < bus.last_frame)) ||
                    ( bus.dir && (bus.frame == '0));
    end

    // Next-state decode: disable, key priority, clamp, and autoplay advance.
    always_comb begin
        nxt_state = state;
        nxt_frame = bus.frame;
        nxt_dir   = bus.dir;
        nxt_presc = presc;
        nxt_adv   = 1'b0;
        if (!bus.en) begin
            nxt_state = IDLE;
            nxt_presc = '0;
            nxt_dir   = 1'b0;
        end else begin
            case (state)
                IDLE: nxt_state = MANUAL;
                MANUAL: begin
                    if (clamp) begin
                        nxt_frame = bus.last_frame;
                    end else if (bus.prev_long) begin
                        nxt_frame = '0;
                    end else if (bus.next_long) begin
                        nxt_state = PLAY;
                        nxt_presc = '0;
                        nxt_dir   = 1'b0;
                    end else if (bus.next_short) begin
                        nxt_frame = (bus.frame == bus.last_frame) ? '0 : up_frame;
                    end else if (bus.prev_short) begin
                        nxt_frame = (bus.frame == '0) ? bus.last_frame : dn_frame;
                    end
                end
                PLAY: begin
                    nxt_presc = presc + DIV_W'(1);
                    if (!bus.pingpong) nxt_dir = 1'b0;
                    if (clamp) begin
                        nxt_frame = bus.last_frame;
                        nxt_dir   = bus.pingpong && (bus.last_frame != '0);
                    end else if (bus.prev_long) begin
                        nxt_state = MANUAL;
                        nxt_frame = '0;
                        nxt_dir   = 1'b0;
                        nxt_presc = '0;
                    end else if (bus.next_long) begin
                        nxt_state = MANUAL;
                        nxt_presc = '0;
                    end else if (presc >= period_m1) begin
                        nxt_presc = '0;
                        nxt_adv   = 1'b1;
                        if (bus.last_frame == '0) begin
                            nxt_frame = '0;
                            nxt_dir   = 1'b0;
                        end else if (!bus.pingpong) begin
                            nxt_frame = (bus.frame == bus.last_frame) ? '0 : up_frame;
                        end else if (go_up) begin
                            nxt_frame = up_frame;
                            nxt_dir   = (up_frame == bus.last_frame);
                        end else begin
                            nxt_frame = dn_frame;
                            nxt_dir   = (dn_frame != '0);
                        end
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // State and registered outputs; enables/running derive from the next state.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            bus.frame    <= '0;
            bus.dir      <= 1'b0;
            bus.adv      <= 1'b0;
            bus.running  <= 1'b0;
            bus.frame_en <= '0;
        end else begin
            state        <= nxt_state;
            presc        <= nxt_presc;
            bus.frame    <= nxt_frame;
            bus.dir      <= nxt_dir;
            bus.adv      <= nxt_adv;
            bus.running  <= (nxt_state == PLAY);
            bus.frame_en <= (nxt_state != IDLE) ? (FRAMES'(1) << nxt_frame) : '0;
        end
    end

endmodule
